// File: rtl/alarm_interval_timer_if.sv
// Bus bundle for alarm_interval_timer.
//
// Purpose: groups the control/request inputs and the status outputs of the
// alarm interval timer so the controller side and the timer side can be
// connected through one port.
//
// Optional feature macro: ALARM_TIMER_CANCEL_EN (adds the cancel request).
//
// Signals:
//   startTimer  request: load selected delay and start counting (1 cycle)
//   interval    delay select, sampled with startTimer
//   reprogram   delay table write strobe
//   paramSel    delay table entry to write
//   timeValue   value to write, in seconds (0 is stored as 1)
//   cancel      abort a running/finished countdown (macro only)
//   clock1Hz    one-cycle pulse every CLOCK_HZ cycles
//   expired     level: selected delay has elapsed
//   busy        countdown in progress
//   remaining   seconds left, for the display driver
//
// Modports: master drives the requests, slave (the timer) drives the status.
interface alarm_interval_timer_if #(
  parameter int VAL_W = 4
);
  logic             startTimer;
  logic [1:0]       interval;
  logic             reprogram;
  logic [1:0]       paramSel;
  logic [VAL_W-1:0] timeValue;
`ifdef ALARM_TIMER_CANCEL_EN
  logic             cancel;
`endif
  logic             clock1Hz;
  logic             expired;
  logic             busy;
  logic [VAL_W-1:0] remaining;

  modport master (
    output startTimer, interval, reprogram, paramSel, timeValue,
`ifdef ALARM_TIMER_CANCEL_EN
    output cancel,
`endif
    input  clock1Hz, expired, busy, remaining
  );

  modport slave (
    input  startTimer, interval, reprogram, paramSel, timeValue,
`ifdef ALARM_TIMER_CANCEL_EN
    input  cancel,
`endif
    output clock1Hz, expired, busy, remaining
  );
endinterface

// File: rtl/alarm_interval_timer.sv
// alarm_interval_timer: timing stage for the anti-theft controller.
//
// Purpose: divides the system clock to a 1 Hz enable pulse, holds a table of
// four programmable delays and counts down the selected delay after a start
// request, reporting expiry and the seconds left.
//
// Optional feature macro: ALARM_TIMER_CANCEL_EN (cancel input on the bus;
// when undefined a countdown ends only by expiry, retrigger or reset).
//
// Ports:
//   clock   system clock
//   resetN  asynchronous active-low reset (state and delay table)
//   bus     alarm_interval_timer_if.slave: requests in, status out
module alarm_interval_timer #(
  parameter int CLOCK_HZ        = 50000000,
  parameter int VAL_W           = 4,
  parameter int T_ARM_DEF       = 6,
  parameter int T_DRIVER_DEF    = 8,
  parameter int T_PASSENGER_DEF = 15,
  parameter int T_ALARM_DEF     = 10
) (
  input logic                  clock,
  input logic                  resetN,
  alarm_interval_timer_if.slave bus
);

  localparam int            PW   = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLOCK_HZ - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [PW-1:0]    r_prescaler;
  logic [VAL_W-1:0] r_remaining;
  logic [VAL_W-1:0] w_nextRemaining;
  logic [VAL_W-1:0] r_table [4];
  logic             w_tick;

  assign w_tick = (r_prescaler == PMAX);

  // Prescaler: free-running divider; a start realigns it to zero so the
  // first tick lands exactly CLOCK_HZ cycles after the start edge.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_prescaler <= '0;
    end else if (bus.startTimer || w_tick) begin
      r_prescaler <= '0;
    end else begin
      r_prescaler <= r_prescaler + 1'b1;
    end
  end

  // Delay table: a zero write is clamped to one second. A start in the same
  // cycle reads the old entry because this update is non-blocking.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_table[0] <= VAL_W'(T_ARM_DEF);
      r_table[1] <= VAL_W'(T_DRIVER_DEF);
      r_table[2] <= VAL_W'(T_PASSENGER_DEF);
      r_table[3] <= VAL_W'(T_ALARM_DEF);
    end else if (bus.reprogram) begin
      r_table[bus.paramSel] <= (bus.timeValue == '0) ? VAL_W'(1) : bus.timeValue;
    end
  end

  // State register, together with the countdown value it travels with.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state     <= IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_nextState;
      r_remaining <= w_nextRemaining;
    end
  end

  // Next-state logic: start beats cancel and beats a coincident tick.
  always_comb begin
    w_nextState     = r_state;
    w_nextRemaining = r_remaining;
    if (bus.startTimer) begin
      w_nextState     = COUNT;
      w_nextRemaining = r_table[bus.interval];
`ifdef ALARM_TIMER_CANCEL_EN
    end else if (bus.cancel && (r_state != IDLE)) begin
      w_nextState     = IDLE;
      w_nextRemaining = '0;
`endif
    end else if ((r_state == COUNT) && w_tick) begin
      if (r_remaining > VAL_W'(1)) begin
        w_nextRemaining = r_remaining - 1'b1;
      end else begin
        w_nextRemaining = '0;
        w_nextState     = DONE;
      end
    end
  end

  // Outputs: busy/expired are decoded from the registered state, so they
  // follow a start or expiry one cycle after the causing edge.
  always_comb begin
    bus.clock1Hz  = w_tick;
    bus.busy      = (r_state == COUNT);
    bus.expired   = (r_state == DONE);
    bus.remaining = r_remaining;
  end

endmodule

// File: tb/tb_alarm_interval_timer.sv
// Testbench for alarm_interval_timer with CLOCK_HZ=10.
// Expectations are pushed into a cycle-tagged scoreboard queue by the
// stimulus; a monitor at every falling edge pops and compares the entries
// due in that cycle.
module tb_alarm_interval_timer;

  logic clock  = 1'b0;
  logic resetN = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   failures = 0;

  alarm_interval_timer_if #(.VAL_W(4)) bus();

  alarm_interval_timer #(
    .CLOCK_HZ(10), .VAL_W(4), .T_ARM_DEF(6), .T_DRIVER_DEF(8),
    .T_PASSENGER_DEF(15), .T_ALARM_DEF(10)
  ) dut (
    .clock(clock),
    .resetN(resetN),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // Posedge counter used to tag expectations.
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      tag;
    logic       p;
    logic       e;
    logic       b;
    logic [3:0] r;
  } exp_t;

  exp_t sbq[$];

  task automatic pushExp(input int at, input string tag, input logic p,
                         input logic e, input logic b, input logic [3:0] r);
    exp_t x;
    x.at = at; x.tag = tag; x.p = p; x.e = e; x.b = b; x.r = r;
    sbq.push_back(x);
  endtask

  // Countdown model: load of n at cycle s, checked for cycles s..s+span.
  task automatic expectCount(input int s, input int n, input int span,
                             input string tag);
    for (int j = 0; j <= span; j++) begin
      logic p;
      p = ((j % 10) == 9);
      if (j < n * 10) pushExp(s + j, tag, p, 1'b0, 1'b1, 4'(n - j / 10));
      else            pushExp(s + j, tag, p, 1'b1, 1'b0, 4'd0);
    end
  endtask

  // Monitor: compares all entries due this cycle; late entries are failures.
  always @(negedge clock) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].at == cyc) begin
        checks++;
        if ({bus.clock1Hz, bus.expired, bus.busy, bus.remaining} !==
            {sbq[i].p, sbq[i].e, sbq[i].b, sbq[i].r}) begin
          failures++;
          $display("[TB] FAIL %s cyc=%0d got p=%b e=%b b=%b r=%0d want p=%b e=%b b=%b r=%0d",
                   sbq[i].tag, cyc, bus.clock1Hz, bus.expired, bus.busy,
                   bus.remaining, sbq[i].p, sbq[i].e, sbq[i].b, sbq[i].r);
        end
        sbq.delete(i);
      end else if (sbq[i].at < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s missed cyc=%0d now=%0d", sbq[i].tag, sbq[i].at, cyc);
        sbq.delete(i);
      end
    end
  end

  task automatic waitCyc(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Issue a one-cycle start (optionally with a same-cycle table write) and
  // push the model of the resulting countdown; s is the load cycle.
  task automatic applyStimulus(input int iv, input int n, input int span,
                               input bit rp, input int rpSel, input int rpVal,
                               input string tag, output int s);
    s = cyc + 1;
    expectCount(s, n, span, tag);
    bus.startTimer = 1'b1;
    bus.interval   = 2'(iv);
    bus.reprogram  = rp;
    bus.paramSel   = 2'(rpSel);
    bus.timeValue  = 4'(rpVal);
    @(posedge clock);
    #1;
    bus.startTimer = 1'b0;
    bus.reprogram  = 1'b0;
  endtask

  task automatic runStart(input int iv, input int n, input int span,
                          input string tag);
    int s;
    applyStimulus(iv, n, span, 1'b0, 0, 0, tag, s);
    waitCyc(s + span);
  endtask

  task automatic writeTable(input int sel, input int val);
    bus.reprogram = 1'b1;
    bus.paramSel  = 2'(sel);
    bus.timeValue = 4'(val);
    @(posedge clock);
    #1;
    bus.reprogram = 1'b0;
  endtask

  task automatic checkOutput();
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    while (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s never compared cyc=%0d", sbq[0].tag, sbq[0].at);
      void'(sbq.pop_front());
    end
  endtask

  // Watchdog: the run must end on its own well before this.
  initial begin
    repeat (20000) @(posedge clock);
    $display("[TB] FAIL watchdog cyc=%0d queue=%0d", cyc, sbq.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    bus.startTimer = 1'b0;
    bus.interval   = 2'd0;
    bus.reprogram  = 1'b0;
    bus.paramSel   = 2'd0;
    bus.timeValue  = 4'd0;
`ifdef ALARM_TIMER_CANCEL_EN
    bus.cancel     = 1'b0;
`endif

    // Reset state, then free-running prescaler: pulses 9, 19, 29 after release.
    pushExp(2, "reset", 1'b0, 1'b0, 1'b0, 4'd0);
    for (int c = 3; c <= 38; c++)
      pushExp(c, "idle", ((c - 3) % 10) == 9, 1'b0, 1'b0, 4'd0);
    waitCyc(3);
    resetN = 1'b1;
    waitCyc(38);

    // Arming delay 6 s, expiry held afterwards.
    runStart(0, 6, 75, "arm");

    // Reprogrammed driver delay, then zero clamped to one second.
    writeTable(1, 3);
    runStart(1, 3, 35, "drv3");
    writeTable(1, 0);
    runStart(1, 1, 15, "drv0");

    // Retrigger at remaining=4, coincident with a tick.
    runStart(2, 15, 119, "pass");
    applyStimulus(3, 10, 105, 1'b0, 0, 0, "retrig", s);

    // Write to entry 3 while it runs does not disturb the count.
    waitCyc(s + 30);
    writeTable(3, 2);
    waitCyc(s + 105);
    runStart(3, 2, 25, "alm2");

    // Same-cycle start and write to that entry loads the old value.
    applyStimulus(3, 2, 25, 1'b1, 3, 7, "same", s);
    waitCyc(s + 25);
    runStart(3, 7, 75, "alm7");

`ifdef ALARM_TIMER_CANCEL_EN
    // Cancel at remaining=5: back to idle, expiry never asserts.
    applyStimulus(0, 6, 13, 1'b0, 0, 0, "precancel", s);
    waitCyc(s + 13);
    for (int j = 14; j <= 74; j++)
      pushExp(s + j, "cancel", (j % 10) == 9, 1'b0, 1'b0, 4'd0);
    bus.cancel = 1'b1;
    @(posedge clock);
    #1;
    bus.cancel = 1'b0;
    waitCyc(s + 74);
`endif

    // Asynchronous reset at remaining=5 mid-cycle, then table defaults.
    applyStimulus(0, 6, 13, 1'b0, 0, 0, "prereset", s);
    waitCyc(s + 14);
    pushExp(s + 14, "async", 1'b0, 1'b0, 1'b0, 4'd0);
    pushExp(s + 15, "inreset", 1'b0, 1'b0, 1'b0, 4'd0);
    pushExp(s + 16, "inreset", 1'b0, 1'b0, 1'b0, 4'd0);
    resetN = 1'b0;
    waitCyc(s + 16);
    resetN = 1'b1;
    runStart(3, 10, 12, "def3");
    runStart(1, 8, 85, "def1");

    checkOutput();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_interval_timer.md
Name: alarm_interval_timer

Overview:
- Upstream timing stage for the anti-theft controller FSM.
- Divides the system clock to a 1 Hz enable pulse, holds four programmable delay values, and counts down the selected delay after startTimer.
- Signals expiry back to the FSM, and exposes the remaining seconds for the 7-segment display driver.
- Delay table is reprogrammable at runtime from board switches/buttons.

Parameters:
CLOCK_HZ, 50000000, system clock cycles per 1 Hz tick (prescaler divisor, >=2)
VAL_W, 4, width of delay values and countdown, in seconds
T_ARM_DEF, 6, reset value for interval 00 (arming delay)
T_DRIVER_DEF, 8, reset value for interval 01 (driver-door entry delay)
T_PASSENGER_DEF, 15, reset value for interval 10 (passenger-door entry delay)
T_ALARM_DEF, 10, reset value for interval 11 (siren-on time)

Ports:
clock  in  1  system clock
resetN  in  1  reset, asynchronous, active-low
startTimer  in  1  single-cycle request: load selected delay and start counting
interval  in  2  delay select, sampled only when startTimer=1
reprogram  in  1  write strobe for delay table
paramSel  in  2  delay table entry written by reprogram
timeValue  in  VAL_W  value written by reprogram, in seconds
clock1Hz  out  1  one-cycle pulse every CLOCK_HZ cycles
expired  out  1  level: selected delay has elapsed
busy  out  1  countdown in progress
remaining  out  VAL_W  seconds left (display)

Behaviour:
- One clock; resetN is asynchronous and active-low; all state resets asynchronously.
- Reset values:
  - prescaler=0; clock1Hz=0; expired=0; busy=0; remaining=0; state=IDLE.
  - Table = {T_ARM_DEF, T_DRIVER_DEF, T_PASSENGER_DEF, T_ALARM_DEF}.
- Prescaler:
  - Counts 0..CLOCK_HZ-1, then wraps.
  - clock1Hz=1 for exactly one cycle when prescaler==CLOCK_HZ-1.
  - Free-running except on start, which forces prescaler to 0.
  - First tick after start is therefore exactly CLOCK_HZ cycles after the start edge.
- Table write:
  - On a clock edge with reprogram=1, table[paramSel] <= timeValue.
  - timeValue==0 is stored as 1 (minimum 1 s).
  - A write never alters a countdown already in progress.
- States: IDLE, COUNT, DONE.
  - Any state, startTimer=1:
    - remaining <= table[interval], using the pre-write value if reprogram hits the same entry in the same cycle.
    - expired <= 0; busy <= 1; prescaler <= 0; go to COUNT.
    - Retrigger during COUNT restarts with the new interval.
  - COUNT, clock1Hz=1, no start:
    - remaining > 1: remaining decrements.
    - remaining == 1: remaining <= 0; expired <= 1; busy <= 0; go to DONE.
  - DONE: expired stays 1 until the next startTimer or reset. The FSM only samples it in its wait state.
  - IDLE / DONE with no start: remaining holds.
- Simultaneous start and tick: start wins; the tick is discarded.
- Latency:
  - startTimer edge to busy=1 and loaded remaining: 1 cycle.
  - Load of N to expired=1: N*CLOCK_HZ cycles, ±0 jitter.
- Reset mid-count: immediate abort; outputs return to reset values; table returns to defaults.

Optional Feature:
- Macro: ALARM_TIMER_CANCEL_EN.
- When defined:
  - Adds input port cancel (1 bit).
  - cancel=1 without startTimer in COUNT or DONE: go to IDLE, busy <= 0, expired <= 0, remaining <= 0.
  - startTimer has priority over cancel.
  - cancel in IDLE has no effect.
- When undefined: no cancel port; a countdown ends only by expiry, retrigger or reset.

Test Plan:
- CLOCK_HZ=10, reset released, idle 35 cycles -> clock1Hz pulses at cycles 9, 19, 29; expired=0, busy=0, remaining=0.
- startTimer with interval=00 -> remaining=6 next cycle; decrements every 10 cycles; expired=1 exactly 60 cycles after start; busy=0; expired stays 1 until next start.
- Write reprogram paramSel=01 timeValue=3, then start interval=01 -> expired after 30 cycles. Repeat with timeValue=0 -> stored as 1, expired after 10 cycles.
- Start interval=10 (15), at remaining=4 retrigger with interval=11 -> remaining=10; expired 100 cycles after the retrigger. Also drive start coincident with a clock1Hz pulse -> no decrement that cycle.
- Reprogram entry 11 to 2 during a running interval=11 count -> running count unaffected; next interval=11 start loads 2. Also: start and reprogram on the same entry in the same cycle -> old value loaded.
- resetN low mid-count (remaining=5) -> outputs 0 asynchronously, table back to defaults. With ALARM_TIMER_CANCEL_EN: cancel at remaining=5 -> IDLE, expired never asserts.
